// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
// through a single full-adder cell. Define SERIAL_ADDER_OVF_EN to add the ovf output.

module serial_adder_fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic             r_c, r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_co, w_last, w_accept;
  logic [WIDTH:0]   w_accx;
  logic [WIDTH-1:0] w_acc_nxt;

  // Operands shift right, so bit 0 always holds operand bit[cnt].
  serial_adder_fa u_fa (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Cin  (r_c),
    .S    (w_s),
    .Cout (w_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  assign w_accx    = {w_s, r_acc};
  assign w_acc_nxt = w_accx[WIDTH:1];

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_c   <= cin;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_co;
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_co;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the last bit r_c is the carry into the MSB and w_co the carry out of it.
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_c ^ w_co;
  end
  assign ovf = r_ovf;
`endif

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter WIDTH SHALL default to 8 and SHALL give the operand and sum width in bits; legal range is 1 to 64.
REQ-003 Port clk SHALL be a 1-bit input: the single clock, rising-edge active.
REQ-004 Port rst_n SHALL be a 1-bit input: asynchronous, active-low reset.
REQ-005 Port start SHALL be a 1-bit input: request to add the values on a, b and cin.
REQ-006 Port a SHALL be a WIDTH-bit input: operand A, sampled only when start is accepted.
REQ-007 Port b SHALL be a WIDTH-bit input: operand B, sampled only when start is accepted.
REQ-008 Port cin SHALL be a 1-bit input: carry-in, sampled only when start is accepted.
REQ-009 Port busy SHALL be a 1-bit output: high while an addition is in progress.
REQ-010 Port done SHALL be a 1-bit output: single-cycle pulse marking a valid result.
REQ-011 Port sum SHALL be a WIDTH-bit output: registered result.
REQ-012 Port cout SHALL be a 1-bit output: registered carry-out of the MSB.

Function
REQ-013 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one internal single-bit full-adder cell instance (inputs A, B, Cin; outputs S, Cout).
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 A start sampled high in IDLE or DONE SHALL be accepted: a, b and cin are captured into operand shift registers and the carry flop, the bit counter is cleared, and the next state is RUN.
REQ-016 A start sampled high in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-017 In RUN, each edge SHALL apply operand bit[cnt] and the carry flop to the cell, shift S into an internal accumulator from the MSB end, load Cout into the carry flop, and increment cnt.
REQ-018 On the RUN edge where cnt equals WIDTH-1, the accumulator (including the final S) SHALL be written to sum, the final Cout to cout, and the next state SHALL be DONE.
REQ-019 Latency: with start accepted at edge 0, done SHALL be high in exactly the cycle following edge WIDTH; busy SHALL be high in the cycles following edges 0 through WIDTH-1.
REQ-020 In DONE, done SHALL be high for one cycle; the next state SHALL be IDLE, or RUN if start is high.
REQ-021 sum and cout SHALL change only at the REQ-018 edge and SHALL hold their value through IDLE and any subsequent RUN until the next completion.
REQ-022 Back-to-back operation SHALL be supported: a start held high continuously SHALL yield one result every WIDTH+1 cycles.
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within a run.
REQ-024 When WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-025 While rst_n is low, the FSM SHALL be in IDLE and busy, done, sum, cout, the counter, the carry flop and the operand registers SHALL all be 0, regardless of clk.
REQ-026 A reset asserted mid-RUN SHALL abort the operation: no done pulse, sum/cout cleared, and start accepted on the first edge after release.

Configuration
REQ-027 When macro SERIAL_ADDER_OVF_EN is defined, the block SHALL add a 1-bit output ovf equal to (carry into MSB) XOR (carry out of MSB), registered and held alongside sum, reset to 0.
REQ-028 When SERIAL_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8, SERIAL_ADDER_OVF_EN defined)
REQ-029 Test: a=0x5A, b=0x3C, cin=0, start pulse -> done exactly 9 cycles later; sum=0x96, cout=0, ovf=1; busy high for exactly 8 cycles.
REQ-030 Test: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
REQ-031 Test: a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1; sum holds 0x00 for 20 idle cycles after done.
REQ-032 Test: start accepted with 0x10+0x20; start pulsed again at RUN cycle 3 with a=0xFF -> single done, sum=0x30, and no second operation.
REQ-033 Test: start held high continuously with 0x01+0x01 -> done every 9 cycles, sum=0x02 each time.
REQ-034 Test: rst_n low at RUN cycle 4 of 0x7F+0x01 -> busy=0, done never pulses, sum=0x00; after release, 0x7F+0x01 -> sum=0x80, ovf=1.
